// File: rtl/scope_trigger_capture_pkg.sv
// Shared types and default widths for the scope capture path (mux -> capture -> readout).
package scope_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_PRETRIG = 128;

    localparam logic TRIG_RISING  = 1'b1;
    localparam logic TRIG_FALLING = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

endpackage

// File: rtl/scope_trigger_capture_ram.sv
// Simple dual-port sample buffer: synchronous write port, registered read port.
module scope_sample_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/scope_trigger_capture.sv
// Level-crossing trigger capture into a circular buffer, frozen for trigger-aligned readout.
module scope_trigger_capture
    import scope_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int PRETRIG = DEF_PRETRIG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              force_trig,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int DEPTH = 2**ADDR_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_vld;
    logic              r_force_pend;

    logic              w_we;
    logic              w_cross;
    logic              w_fire;
    logic              w_last_pre;
    logic              w_last_post;
    logic [ADDR_W-1:0] w_rd_phys;

    assign busy      = (r_state == PREFILL) || (r_state == WAIT_TRIG) || (r_state == POST);
    assign triggered = (r_state == POST) || (r_state == DONE);
    assign done      = (r_state == DONE);
    assign trig_addr = r_trig_addr;

    assign w_we        = busy && sample_valid && !arm;
    assign w_last_pre  = (r_count == ADDR_W'(PRETRIG - 1));
    assign w_last_post = (r_count == ADDR_W'(DEPTH - PRETRIG - 2));
    assign w_cross     = (trig_rising == TRIG_RISING)
                       ? ((r_prev < trig_level) && (sample >= trig_level))
                       : ((r_prev > trig_level) && (sample <= trig_level));
    assign w_fire      = (r_state == WAIT_TRIG) && w_we && (r_force_pend || (r_prev_vld && w_cross));

    // Relative index 0 is the oldest sample, PRETRIG places before the trigger.
    assign w_rd_phys = r_trig_addr - ADDR_W'(PRETRIG) + rd_addr;

    // NOTE: sequential state uses non-blocking assignments with the async reset in the sensitivity list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = PREFILL;
        end else if (sample_valid) begin
            case (r_state)
                PREFILL:   if (w_last_pre)  w_state_nxt = WAIT_TRIG;
                WAIT_TRIG: if (w_fire)      w_state_nxt = POST;
                POST:      if (w_last_post) w_state_nxt = DONE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_trig_addr  <= '0;
            r_prev       <= '0;
            r_prev_vld   <= 1'b0;
            r_force_pend <= 1'b0;
        end else if (arm) begin
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_prev_vld   <= 1'b0;
            r_force_pend <= 1'b0;
        end else begin
            if ((r_state == WAIT_TRIG) && force_trig) begin
                r_force_pend <= 1'b1;
            end
            if (w_we) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_prev     <= sample;
                r_prev_vld <= 1'b1;
                case (r_state)
                    PREFILL: r_count <= w_last_pre ? '0 : r_count + 1'b1;
                    WAIT_TRIG: begin
                        if (w_fire) begin
                            r_trig_addr  <= r_wr_ptr;
                            r_count      <= '0;
                            r_force_pend <= 1'b0;
                        end
                    end
                    POST:    r_count <= r_count + 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    scope_sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (sample),
        .i_rd_en   (rd_en && (r_state == DONE)),
        .i_rd_addr (w_rd_phys),
        .o_rd_data (rd_data)
    );

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Self-checking bench for scope_trigger_capture: table-driven readout plus hand-written capture sequences.
module tb_scope_trigger_capture;
    import scope_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ADDR_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic          arm;
    logic [DW-1:0] trig_level;
    logic          trig_rising;
    logic          force_trig;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_addr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int            scen;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_vec_t;

    rd_vec_t       rd_tbl[$];
    logic [DW-1:0] sb_q[$];
    string         sb_name[$];

    scope_trigger_capture dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .arm          (arm),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .force_trig   (force_trig),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .trig_addr    (trig_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d);
        sample_valid = v;
        sample       = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic arm_pulse(input logic v);
        arm          = 1'b1;
        sample_valid = v;
        sample       = 8'h40;
        tick();
        arm          = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic force_pulse();
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
    endtask

    // Issue one read; the expected byte is queued now and compared when rd_data appears.
    task automatic rd_req(input logic [AW-1:0] a, input logic [DW-1:0] e, input string nm);
        rd_en   = 1'b1;
        rd_addr = a;
        sb_q.push_back(e);
        sb_name.push_back(nm);
        tick();
        rd_en = 1'b0;
        check(sb_name.pop_front(), 32'(rd_data), 32'(sb_q.pop_front()));
    endtask

    task automatic run_table(input int scen);
        foreach (rd_tbl[k]) begin
            if (rd_tbl[k].scen == scen) begin
                rd_req(rd_tbl[k].addr, rd_tbl[k].exp, $sformatf("s%0d_rd%0d", scen, rd_tbl[k].addr));
            end
        end
    endtask

    initial begin
        // scenario 1: rising ramp
        rd_tbl.push_back('{1, 9'd0,   8'h00});
        rd_tbl.push_back('{1, 9'd1,   8'h01});
        rd_tbl.push_back('{1, 9'd128, 8'h80});
        rd_tbl.push_back('{1, 9'd255, 8'hFF});
        rd_tbl.push_back('{1, 9'd256, 8'h00});
        rd_tbl.push_back('{1, 9'd511, 8'hFF});
        // scenario 2: wrapped buffer, trigger at physical 88
        rd_tbl.push_back('{2, 9'd0,   8'h10});
        rd_tbl.push_back('{2, 9'd127, 8'h10});
        rd_tbl.push_back('{2, 9'd128, 8'h90});
        rd_tbl.push_back('{2, 9'd129, 8'h91});
        rd_tbl.push_back('{2, 9'd511, 8'h0F});
        // scenario 3: falling trigger with sample gaps
        rd_tbl.push_back('{3, 9'd0,   8'hF0});
        rd_tbl.push_back('{3, 9'd127, 8'hF0});
        rd_tbl.push_back('{3, 9'd128, 8'h20});
        rd_tbl.push_back('{3, 9'd511, 8'h20});

        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        arm          = 1'b0;
        trig_level   = 8'h80;
        trig_rising  = TRIG_RISING;
        force_trig   = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_triggered", 32'(triggered), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_trig_addr", 32'(trig_addr), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick();
        step(1'b1, 8'h33);
        check("idle_no_capture", 32'(busy), 32'd0);

        // Scenario 1: ramp, trigger on 0x80 at physical 128.
        arm_pulse(1'b0);
        check("s1_busy_after_arm", 32'(busy), 32'd1);
        for (int i = 0; i < 512; i++) begin
            step(1'b1, 8'(i));
            if (i == 127) check("s1_no_trig_prefill", 32'(triggered), 32'd0);
            if (i == 128) begin
                check("s1_triggered", 32'(triggered), 32'd1);
                check("s1_trig_addr", 32'(trig_addr), 32'd128);
            end
            if (i == 510) check("s1_not_done_511", 32'(done), 32'd0);
        end
        check("s1_done_512", 32'(done), 32'd1);
        check("s1_busy_done", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h55);
        run_table(1);

        // Read latency: rd_data must not move before the clock, then update exactly one edge later.
        rd_en   = 1'b1;
        rd_addr = 9'd5;
        sb_q.push_back(8'h05);
        sb_name.push_back("lat_rd5");
        #1;
        check("lat_before_edge", 32'(rd_data), 32'hFF);
        tick();
        rd_en = 1'b0;
        check(sb_name.pop_front(), 32'(rd_data), 32'(sb_q.pop_front()));
        tick();
        check("lat_hold", 32'(rd_data), 32'h05);

        // Scenario 2: wrap; 600 x 0x10 then 0x90 ramp, trigger at physical 88.
        arm_pulse(1'b0);
        check("s2_done_cleared", 32'(done), 32'd0);
        rd_req(9'd0, 8'h05, "rd_outside_done_hold");
        for (int i = 0; i < 600; i++) step(1'b1, 8'h10);
        check("s2_no_trig", 32'(triggered), 32'd0);
        for (int k = 0; k < 384; k++) begin
            step(1'b1, 8'(8'h90 + k));
            if (k == 0) check("s2_trig_addr", 32'(trig_addr), 32'd88);
            if (k == 382) check("s2_not_done", 32'(done), 32'd0);
        end
        check("s2_done", 32'(done), 32'd1);
        run_table(2);

        // Scenario 3: falling, valid every other cycle; gaps carry a would-trigger value.
        trig_rising = TRIG_FALLING;
        arm_pulse(1'b0);
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 8'hF0);
            step(1'b0, 8'h00);
        end
        check("s3_gap_no_trig", 32'(triggered), 32'd0);
        step(1'b1, 8'h20);
        check("s3_triggered", 32'(triggered), 32'd1);
        check("s3_trig_addr", 32'(trig_addr), 32'd200);
        step(1'b0, 8'h00);
        for (int j = 0; j < 383; j++) begin
            step(1'b1, 8'h20);
            if (j == 381) begin
                check("s3_not_done_382", 32'(done), 32'd0);
                step(1'b0, 8'h20);
                step(1'b0, 8'h20);
                check("s3_gap_frozen", 32'(done), 32'd0);
            end else begin
                step(1'b0, 8'h00);
            end
        end
        check("s3_done_383", 32'(done), 32'd1);
        run_table(3);

        // Scenario 4: force trigger; pulse in PREFILL is ignored, pulse in WAIT_TRIG arms next sample.
        trig_rising = TRIG_RISING;
        arm_pulse(1'b0);
        for (int i = 0; i < 140; i++) begin
            if (i == 60) force_pulse();
            step(1'b1, 8'h40);
        end
        check("s4_prefill_force_ignored", 32'(triggered), 32'd0);
        force_pulse();
        check("s4_force_pending_only", 32'(triggered), 32'd0);
        step(1'b0, 8'h40);
        check("s4_force_gap", 32'(triggered), 32'd0);
        step(1'b1, 8'h40);
        check("s4_force_triggered", 32'(triggered), 32'd1);
        check("s4_force_trig_addr", 32'(trig_addr), 32'd140);

        // Scenario 5: re-arm mid-POST; the arm-cycle sample is dropped and wr_ptr restarts at 0.
        for (int i = 0; i < 10; i++) step(1'b1, 8'h40);
        arm_pulse(1'b1);
        check("s5_rearm_done", 32'(done), 32'd0);
        check("s5_rearm_triggered", 32'(triggered), 32'd0);
        check("s5_rearm_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 128; i++) step(1'b1, 8'h40);
        force_pulse();
        arm_pulse(1'b1);
        check("s5_arm_wins", 32'(triggered), 32'd0);
        for (int i = 0; i < 131; i++) step(1'b1, 8'h40);
        check("s5_pending_cleared", 32'(triggered), 32'd0);
        force_pulse();
        step(1'b1, 8'h40);
        check("s5_restart_trig_addr", 32'(trig_addr), 32'd131);

        // Async reset mid-WAIT_TRIG: outputs clear before any clock edge.
        arm_pulse(1'b0);
        for (int i = 0; i < 130; i++) step(1'b1, 8'h40);
        check("s6_waiting", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_busy", 32'(busy), 32'd0);
        check("s6_async_trig_addr", 32'(trig_addr), 32'd0);
        check("s6_async_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h90);
        check("s6_idle_busy", 32'(busy), 32'd0);
        check("s6_idle_done", 32'(done), 32'd0);
        rd_req(9'd130, 8'h00, "s6_rd_in_idle_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
